// File: rtl/ex_alu_unit.sv
// Execute-stage ALU block: operand muxes, 32-bit ALU, branch-target adder,
// all results registered into the EX/MEM boundary.

package ex_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_NOR   = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_ADDU  = 4'd11,
        ALU_SUBU  = 4'd12,
        ALU_SLTU  = 4'd13,
        ALU_PASSB = 4'd14,
        ALU_ZERO  = 4'd15
    } alu_op_e;

endpackage

module ex_alu_unit
    import ex_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            stall,
    input  logic            flush,
    input  logic [3:0]      alu_operation,
    input  logic            alu_src,
    input  logic            shamt_sel,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic [XLEN-1:0] imm_data,
    input  logic [4:0]      shamt,
    input  logic [XLEN-1:0] pc_incremented,
    input  logic [XLEN-1:0] branch_offset,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            negative,
    output logic [XLEN-1:0] branch_target
);

    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      shift_amt;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] target_sum;
    alu_op_e         op;

    assign op         = alu_op_e'(alu_operation);
    assign operand_a  = shamt_sel ? {{(XLEN-5){1'b0}}, shamt} : rs_data;
    assign operand_b  = alu_src ? imm_data : rt_data;
    // Shifts consume only the low five bits of A; the upper bits are ignored.
    assign shift_amt  = operand_a[4:0];
    assign target_sum = pc_incremented + branch_offset;

    always_comb begin
        // NOTE: result gets a default before the case so every path assigns
        // it; without that an unlisted opcode would infer a latch.
        result = '0;
        unique case (op)
            ALU_ADD,
            ALU_ADDU:  result = operand_a + operand_b;
            ALU_SUB,
            ALU_SUBU:  result = operand_a - operand_b;
            ALU_AND:   result = operand_a & operand_b;
            ALU_OR:    result = operand_a | operand_b;
            ALU_XOR:   result = operand_a ^ operand_b;
            ALU_NOR:   result = ~(operand_a | operand_b);
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
            ALU_SLL:   result = operand_b << shift_amt;
            ALU_SRL:   result = operand_b >> shift_amt;
            ALU_SRA:   result = $unsigned($signed(operand_b) >>> shift_amt);
            ALU_LUI:   result = {operand_b[15:0], {(XLEN-16){1'b0}}};
            ALU_PASSB: result = operand_b;
            ALU_ZERO:  result = '0;
            default:   result = '0;
        endcase
    end

    // Flush beats stall; reset values are stored zeros, so zero reads 0 after
    // reset even though the cleared result is numerically zero.
    always_ff @(posedge clk or posedge rst_b) begin
        // NOTE: registered state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst_b) begin
            alu_result    <= '0;
            zero          <= 1'b0;
            negative      <= 1'b0;
            branch_target <= '0;
        end else if (flush) begin
            alu_result    <= '0;
            zero          <= 1'b0;
            negative      <= 1'b0;
            branch_target <= '0;
        end else if (!stall) begin
            alu_result    <= result;
            zero          <= (result == '0);
            negative      <= result[XLEN-1];
            branch_target <= target_sum;
        end
    end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed plus randomized scoreboard bench for ex_alu_unit: expectations are
// queued when operands are driven and compared one edge later.

module tb_ex_alu_unit;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        negative;
        logic [31:0] target;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        stall;
    logic        flush;
    logic [3:0]  alu_operation;
    logic        alu_src;
    logic        shamt_sel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_data;
    logic [4:0]  shamt;
    logic [31:0] pc_incremented;
    logic [31:0] branch_offset;
    logic [31:0] alu_result;
    logic        zero;
    logic        negative;
    logic [31:0] branch_target;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t held;

    always #5 clk = ~clk;

    ex_alu_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .stall          (stall),
        .flush          (flush),
        .alu_operation  (alu_operation),
        .alu_src        (alu_src),
        .shamt_sel      (shamt_sel),
        .rs_data        (rs_data),
        .rt_data        (rt_data),
        .imm_data       (imm_data),
        .shamt          (shamt),
        .pc_incremented (pc_incremented),
        .branch_offset  (branch_offset),
        .alu_result     (alu_result),
        .zero           (zero),
        .negative       (negative),
        .branch_target  (branch_target)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare all four outputs against it.
    task automatic compare_front(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        check32({tag, "_result"}, alu_result, e.result);
        check1 ({tag, "_zero"}, zero, e.zero);
        check1 ({tag, "_neg"}, negative, e.negative);
        check32({tag, "_target"}, branch_target, e.target);
    endtask

    task automatic drive(input logic [3:0] op, input logic src, input logic ssel,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] sa);
        alu_operation = op;
        alu_src       = src;
        shamt_sel     = ssel;
        rs_data       = rs;
        rt_data       = rt;
        imm_data      = imm;
        shamt         = sa;
    endtask

    // Queue the expectation, let one edge pass, then compare off the edge.
    task automatic step(input string tag, input logic [31:0] r, input logic z,
                        input logic n, input logic [31:0] t);
        sb.push_back({r, z, n, t});
        @(posedge clk);
        #1;
        compare_front(tag);
    endtask

    // Independent reference for the randomized sweep.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0] s;
        s = a[4:0];
        case (op)
            4'd0, 4'd11: return a + b;
            4'd1, 4'd12: return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            4'd7:  return b << s;
            4'd8:  return b >> s;
            4'd9:  return 32'(signed'(b) >>> s);
            4'd10: return {b[15:0], 16'h0000};
            4'd13: return (a < b) ? 32'd1 : 32'd0;
            4'd14: return b;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] r, a, b, t;
        logic [3:0]  op;
        logic        src, ssel;
        logic [4:0]  sa;

        rst_b = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        pc_incremented = 32'h0000_0100;
        branch_offset  = 32'h0000_0010;
        drive(4'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 5'd0);

        #1;
        sb.push_back('0);
        compare_front("reset_state");
        @(posedge clk);
        #1;
        sb.push_back('0);
        compare_front("reset_held");

        #3 rst_b = 1'b0;
        t = 32'h0000_0110;
        drive(4'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0, 5'd0);
        step("add_5_7", 32'd12, 1'b0, 1'b0, t);

        drive(4'd1, 1'b0, 1'b0, 32'd3, 32'd3, 32'h0, 5'd0);
        step("sub_eq", 32'd0, 1'b1, 1'b0, t);
        drive(4'd1, 1'b0, 1'b0, 32'd2, 32'd5, 32'h0, 5'd0);
        step("sub_neg", 32'hFFFF_FFFD, 1'b0, 1'b1, t);
        drive(4'd6, 1'b0, 1'b0, 32'd2, 32'd5, 32'h0, 5'd0);
        step("slt_2_5", 32'd1, 1'b0, 1'b0, t);
        drive(4'd13, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd0);
        step("sltu_big", 32'd0, 1'b1, 1'b0, t);
        drive(4'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd0);
        step("slt_signed", 32'd1, 1'b0, 1'b0, t);

        drive(4'd7, 1'b0, 1'b1, 32'hFFFF_FFE0, 32'h8000_0010, 32'h0, 5'd4);
        step("sll_shamt", 32'h0000_0100, 1'b0, 1'b0, t);
        drive(4'd8, 1'b0, 1'b1, 32'hFFFF_FFE0, 32'h8000_0010, 32'h0, 5'd4);
        step("srl_shamt", 32'h0800_0001, 1'b0, 1'b0, t);
        drive(4'd9, 1'b0, 1'b1, 32'hFFFF_FFE0, 32'h8000_0010, 32'h0, 5'd4);
        step("sra_shamt", 32'hF800_0001, 1'b0, 1'b1, t);
        drive(4'd9, 1'b0, 1'b1, 32'h0, 32'h4000_0000, 32'h0, 5'd4);
        step("sra_pos", 32'h0400_0000, 1'b0, 1'b0, t);
        drive(4'd7, 1'b0, 1'b0, 32'h0000_0024, 32'h8000_0010, 32'h0, 5'd0);
        step("sll_rs_amt", 32'h0000_0100, 1'b0, 1'b0, t);

        drive(4'd10, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0000_1234, 5'd0);
        step("lui", 32'h1234_0000, 1'b0, 1'b0, t);
        drive(4'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'd1, 5'd0);
        step("add_wrap", 32'd0, 1'b1, 1'b0, t);

        drive(4'd2, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'd0);
        step("and", 32'h0000_F000, 1'b0, 1'b0, t);
        drive(4'd3, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'd0);
        step("or", 32'h0000_FFF0, 1'b0, 1'b0, t);
        drive(4'd4, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'd0);
        step("xor", 32'h0000_0FF0, 1'b0, 1'b0, t);
        drive(4'd5, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'd0);
        step("nor", 32'hFFFF_000F, 1'b0, 1'b1, t);
        drive(4'd11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0, 5'd0);
        step("addu", 32'd1, 1'b0, 1'b0, t);
        drive(4'd12, 1'b0, 1'b0, 32'd0, 32'd1, 32'h0, 5'd0);
        step("subu", 32'hFFFF_FFFF, 1'b0, 1'b1, t);
        drive(4'd13, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h0, 5'd0);
        step("sltu_small", 32'd1, 1'b0, 1'b0, t);
        drive(4'd14, 1'b0, 1'b0, 32'd0, 32'hDEAD_BEEF, 32'h0, 5'd0);
        step("passb", 32'hDEAD_BEEF, 1'b0, 1'b1, t);
        drive(4'd15, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd0);
        step("op15", 32'd0, 1'b1, 1'b0, t);

        pc_incremented = 32'h0040_0004;
        branch_offset  = 32'hFFFF_FFF8;
        drive(4'd0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h0, 5'd0);
        step("branch_add_ovf", 32'h8000_0000, 1'b0, 1'b1, 32'h003F_FFFC);

        pc_incremented = 32'h0000_2000;
        branch_offset  = 32'h0000_0040;
        drive(4'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0, 5'd0);
        step("pre_stall", 32'd12, 1'b0, 1'b0, 32'h0000_2040);
        stall = 1'b1;
        pc_incremented = 32'h0000_9000;
        drive(4'd1, 1'b0, 1'b0, 32'd3, 32'd3, 32'h0, 5'd0);
        step("stall_hold", 32'd12, 1'b0, 1'b0, 32'h0000_2040);
        step("stall_hold2", 32'd12, 1'b0, 1'b0, 32'h0000_2040);
        flush = 1'b1;
        step("stall_flush", 32'd0, 1'b0, 1'b0, 32'd0);
        flush = 1'b0;
        stall = 1'b0;
        step("post_flush", 32'd0, 1'b1, 1'b0, 32'h0000_9040);

        // Asynchronous reset in the middle of a cycle must clear immediately.
        drive(4'd14, 1'b0, 1'b0, 32'd0, 32'hCAFE_0001, 32'h0, 5'd0);
        step("pre_reset", 32'hCAFE_0001, 1'b0, 1'b1, 32'h0000_9040);
        #2 rst_b = 1'b1;
        #1;
        sb.push_back('0);
        compare_front("async_reset");
        #1 rst_b = 1'b0;
        step("after_reset", 32'hCAFE_0001, 1'b0, 1'b1, 32'h0000_9040);

        for (int i = 0; i < 40; i++) begin
            op   = 4'($urandom_range(0, 15));
            src  = 1'($urandom_range(0, 1));
            ssel = 1'($urandom_range(0, 1));
            sa   = 5'($urandom);
            drive(op, src, ssel, $urandom, $urandom, $urandom, sa);
            pc_incremented = $urandom;
            branch_offset  = $urandom;
            a = ssel ? {27'd0, sa} : rs_data;
            b = src ? imm_data : rt_data;
            r = model(op, a, b);
            step($sformatf("rand_%0d_op%0d", i, op), r, (r == 32'd0), r[31],
                 pc_incremented + branch_offset);
        end

        held = '0;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL queue_drained observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
